data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL: MemWrite_M  input  1  store request this cycle.
REQ-004 SHALL: MemOp_M  input  3  access size/sign: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed, 101-111 reserved.
REQ-005 SHALL: Addr_M  input  32  byte address from the E/M register.
REQ-006 SHALL: WriteData_M  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL: PC_M  input  32  PC of the instruction in M, used only for the store trace.
REQ-008 SHALL: ReadData_M  output  32  load result, extended to 32 bits, feeding the M/W register.
REQ-009 SHALL: AddrErr_M  output  1  combinational flag for misaligned, out-of-range or reserved-op access.
REQ-010 SHALL: StoreValid  output  1  registered; 1 for exactly one cycle after a committed store.
REQ-011 SHALL: StorePC, StoreAddr, StoreData  output  32 each  registered trace: PC, word-aligned address, full merged word of the committed store.

Function
REQ-012 SHALL: Storage is 4096 x 32-bit words at byte addresses 0x0000_0000-0x0000_3FFF; word index = Addr_M[13:2].
REQ-013 SHALL: In range means Addr_M[31:14] == 0.
REQ-014 SHALL: Misaligned means half access with Addr_M[0]=1, or word access with Addr_M[1:0]!=0.
REQ-015 SHALL: AddrErr_M = out-of-range OR misaligned OR reserved MemOp_M, evaluated whenever MemWrite_M=1 or a read is presented; it is purely combinational.
REQ-016 SHALL: Reads are combinational from current array contents, with zero cycles of latency.
REQ-017 SHALL: Read byte lane = Addr_M[1:0]; half lane = Addr_M[1] (0 -> [15:0], 1 -> [31:16]).
REQ-018 SHALL: Unsigned loads zero-extend; signed loads sign-extend from bit 7 (byte) or bit 15 (half).
REQ-019 SHALL: ReadData_M = 0 whenever AddrErr_M=1.
REQ-020 SHALL: A store commits at posedge clk only when MemWrite_M=1, AddrErr_M=0 and reset=0.
REQ-021 SHALL: A word store replaces all 4 bytes; a half store replaces only the selected 16-bit lane with WriteData_M[15:0]; a byte store replaces only the selected byte with WriteData_M[7:0]. Other lanes are preserved.
REQ-022 SHALL: For stores, MemOp_M 001/010 both mean half and 011/100 both mean byte; signedness is ignored.
REQ-023 SHALL: When a read and a store hit the same word in one cycle, ReadData_M returns the pre-store contents; the new value is visible from the next cycle.
REQ-024 SHALL: A rejected store (AddrErr_M=1) leaves memory and all trace outputs unchanged, and StoreValid=0 in the next cycle.
REQ-025 SHALL: On a committed store, the next cycle shows StoreValid=1, StorePC=PC_M, StoreAddr={Addr_M[31:2],2'b00} and StoreData = merged word as written. With no store, StoreValid=0 and the other trace registers hold their values.
REQ-026 SHALL: Back-to-back stores on consecutive cycles each commit and each produce their own one-cycle trace.

Reset
REQ-027 SHALL: While reset=1 at posedge clk, all 4096 words clear to 0 in that same cycle, and StoreValid, StorePC, StoreAddr and StoreData become 0.
REQ-028 SHALL: Reset has priority over a simultaneous store; the store is discarded.
REQ-029 SHALL: Reset asserted in the middle of a store sequence loses only the store presented in the reset cycle; earlier stores are wiped by the clear.
REQ-030 SHALL: ReadData_M and AddrErr_M remain combinational during reset; after the clear, ReadData_M reads 0 for any in-range aligned address.

Verification
REQ-031 SHALL: Word store 0xDEADBEEF @0x10, then lw @0x10 -> ReadData_M=0xDEADBEEF; in the cycle after the store, StoreValid=1, StoreAddr=0x10, StoreData=0xDEADBEEF.
REQ-032 SHALL: After REQ-031, sb 0x5A @0x13, then lw @0x10 -> 0x5AADBEEF; lb @0x13 -> 0x0000005A; lh @0x12 (signed) -> 0x00005AAD; lbu @0x11 -> 0x000000BE; lb @0x11 -> 0xFFFFFFBE.
REQ-033 SHALL: sh 0x8001 @0x22 over word 0 -> word=0x80010000; lh @0x22 -> 0xFFFF8001; lhu @0x22 -> 0x00008001.
REQ-034 SHALL: sw @0x11, sh @0x03, sw @0x4000 and MemOp_M=101 -> each gives AddrErr_M=1, ReadData_M=0, no memory change, StoreValid=0 the next cycle.
REQ-035 SHALL: A store and a read to the same word in one cycle -> the read returns the old value, and the next cycle returns the new value.
REQ-036 SHALL: Fill 0x0, 0x3FFC and 0x100, then assert reset together with a store -> all three words read 0, the store is discarded, and all trace outputs are 0.

Source files
------------

// File: rtl/data_mem.sv
// Data memory for the M stage: 4096 x 32-bit words, combinational sized/extended loads,
// byte/half/word stores committed on posedge clk, and a registered one-cycle store trace.
module data_mem (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite_M,
  input  logic [2:0]  MemOp_M,
  input  logic [31:0] Addr_M,
  input  logic [31:0] WriteData_M,
  input  logic [31:0] PC_M,
  output logic [31:0] ReadData_M,
  output logic        AddrErr_M,
  output logic        StoreValid,
  output logic [31:0] StorePC,
  output logic [31:0] StoreAddr,
  output logic [31:0] StoreData
);

  localparam int unsigned Depth = 4096;

  localparam logic [2:0] OpWord  = 3'b000;
  localparam logic [2:0] OpHalfU = 3'b001;
  localparam logic [2:0] OpHalfS = 3'b010;
  localparam logic [2:0] OpByteU = 3'b011;
  localparam logic [2:0] OpByteS = 3'b100;

  logic [31:0] mem [Depth];

  logic [11:0] word_idx;
  logic        is_word, is_half, is_byte, is_reserved;
  logic        out_of_range, misaligned;
  logic [31:0] rd_word, load_data, wr_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        store_commit;

  assign word_idx     = Addr_M[13:2];
  assign is_word      = (MemOp_M == OpWord);
  assign is_half      = (MemOp_M == OpHalfU) || (MemOp_M == OpHalfS);
  assign is_byte      = (MemOp_M == OpByteU) || (MemOp_M == OpByteS);
  assign is_reserved  = !(is_word || is_half || is_byte);
  assign out_of_range = |Addr_M[31:14];
  assign misaligned   = (is_half && Addr_M[0]) || (is_word && (Addr_M[1:0] != 2'b00));
  assign AddrErr_M    = out_of_range || misaligned || is_reserved;
  assign store_commit = MemWrite_M && !AddrErr_M;

  // Reads see the array before any same-cycle store lands.
  assign rd_word = mem[word_idx];

  always_comb begin
    unique case (Addr_M[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
    endcase
    rd_half = Addr_M[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    case (MemOp_M)
      OpWord:  load_data = rd_word;
      OpHalfU: load_data = {16'h0000, rd_half};
      OpHalfS: load_data = {{16{rd_half[15]}}, rd_half};
      OpByteU: load_data = {24'h000000, rd_byte};
      OpByteS: load_data = {{24{rd_byte[7]}}, rd_byte};
      default: load_data = '0;
    endcase
    ReadData_M = AddrErr_M ? 32'h0 : load_data;
  end

  // Merge the store into the current word so untouched lanes are preserved.
  always_comb begin
    wr_word = rd_word;
    if (is_word) begin
      wr_word = WriteData_M;
    end else if (is_half) begin
      if (Addr_M[1]) wr_word[31:16] = WriteData_M[15:0];
      else           wr_word[15:0]  = WriteData_M[15:0];
    end else if (is_byte) begin
      unique case (Addr_M[1:0])
        2'd0: wr_word[7:0]   = WriteData_M[7:0];
        2'd1: wr_word[15:8]  = WriteData_M[7:0];
        2'd2: wr_word[23:16] = WriteData_M[7:0];
        2'd3: wr_word[31:24] = WriteData_M[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
      StoreValid <= 1'b0;
      StorePC    <= '0;
      StoreAddr  <= '0;
      StoreData  <= '0;
    end else begin
      StoreValid <= store_commit;
      if (store_commit) begin
        mem[word_idx] <= wr_word;
        StorePC       <= PC_M;
        StoreAddr     <= {Addr_M[31:2], 2'b00};
        StoreData     <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: expectations are queued when stimulus is driven and popped
// and asserted against the DUT when the corresponding output is sampled.
module tb_data_mem;

  logic        clk;
  logic        reset;
  logic        MemWrite_M;
  logic [2:0]  MemOp_M;
  logic [31:0] Addr_M;
  logic [31:0] WriteData_M;
  logic [31:0] PC_M;
  logic [31:0] ReadData_M;
  logic        AddrErr_M;
  logic        StoreValid;
  logic [31:0] StorePC;
  logic [31:0] StoreAddr;
  logic [31:0] StoreData;

  data_mem dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite_M  (MemWrite_M),
    .MemOp_M     (MemOp_M),
    .Addr_M      (Addr_M),
    .WriteData_M (WriteData_M),
    .PC_M        (PC_M),
    .ReadData_M  (ReadData_M),
    .AddrErr_M   (AddrErr_M),
    .StoreValid  (StoreValid),
    .StorePC     (StorePC),
    .StoreAddr   (StoreAddr),
    .StoreData   (StoreData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;

  item_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [2:0] W = 3'b000, HU = 3'b001, HS = 3'b010, BU = 3'b011, BS = 3'b100;

  task automatic push(input string tag, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    item_t it;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
    end else begin
      it = sb_q.pop_front();
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc);
    MemWrite_M  = we;
    MemOp_M     = op;
    Addr_M      = addr;
    WriteData_M = wd;
    PC_M        = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational load: check data and error flag in the same cycle.
  task automatic load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] exp);
    drive(1'b0, op, addr, 32'h0, 32'h0);
    push({tag, "_data"}, exp);
    push({tag, "_err"}, 32'h0);
    #1;
    pop_check(ReadData_M);
    pop_check({31'h0, AddrErr_M});
  endtask

  task automatic check_trace(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                             input logic [31:0] data);
    push({tag, "_valid"}, 32'h1);
    push({tag, "_pc"}, pc);
    push({tag, "_addr"}, addr);
    push({tag, "_data"}, data);
    pop_check({31'h0, StoreValid});
    pop_check(StorePC);
    pop_check(StoreAddr);
    pop_check(StoreData);
  endtask

  task automatic store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] merged);
    drive(1'b1, op, addr, wd, pc);
    tick();
    drive(1'b0, W, 32'h0, 32'h0, 32'h0);
    check_trace(tag, pc, {addr[31:2], 2'b00}, merged);
  endtask

  // Rejected store: error flag and zero data now, no trace next cycle, trace regs held.
  task automatic bad_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] held_addr, input logic [31:0] held_data);
    drive(1'b1, op, addr, 32'hCAFEF00D, 32'h0000_0BAD);
    push({tag, "_err"}, 32'h1);
    push({tag, "_rdata"}, 32'h0);
    #1;
    pop_check({31'h0, AddrErr_M});
    pop_check(ReadData_M);
    tick();
    drive(1'b0, W, 32'h0, 32'h0, 32'h0);
    push({tag, "_nvalid"}, 32'h0);
    push({tag, "_hold_addr"}, held_addr);
    push({tag, "_hold_data"}, held_data);
    pop_check({31'h0, StoreValid});
    pop_check(StoreAddr);
    pop_check(StoreData);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, W, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    push("rst_valid", 32'h0); pop_check({31'h0, StoreValid});
    push("rst_pc", 32'h0);    pop_check(StorePC);
    push("rst_addr", 32'h0);  pop_check(StoreAddr);
    push("rst_data", 32'h0);  pop_check(StoreData);
    reset = 1'b0;
    load("rst_mem", W, 32'h10, 32'h0);

    // Word store then sub-word accesses on the same word
    store("sw10", W, 32'h10, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF);
    tick();
    push("idle_valid", 32'h0);       pop_check({31'h0, StoreValid});
    push("idle_data", 32'hDEADBEEF); pop_check(StoreData);
    load("lw10", W, 32'h10, 32'hDEADBEEF);
    store("sb13", BU, 32'h13, 32'hFFFFFF5A, 32'h104, 32'h5AADBEEF);
    load("lw10b", W, 32'h10, 32'h5AADBEEF);
    load("lb13", BS, 32'h13, 32'h0000005A);
    load("lh12", HS, 32'h12, 32'h00005AAD);
    load("lbu11", BU, 32'h11, 32'h000000BE);
    load("lb11", BS, 32'h11, 32'hFFFFFFBE);
    load("lhu10", HU, 32'h10, 32'h0000BEEF);

    // Half store into an empty word, upper lane; signed store op treated as plain half
    store("sh22", HS, 32'h22, 32'h12348001, 32'h108, 32'h80010000);
    load("lw20", W, 32'h20, 32'h80010000);
    load("lh22", HS, 32'h22, 32'hFFFF8001);
    load("lhu22", HU, 32'h22, 32'h00008001);
    store("sb21", BS, 32'h21, 32'h000000C3, 32'h10C, 32'h8001C300);

    // Rejected accesses
    bad_store("sw_mis", W, 32'h11, 32'h20, 32'h8001C300);
    bad_store("sh_mis", HU, 32'h03, 32'h20, 32'h8001C300);
    bad_store("sw_oor", W, 32'h4000, 32'h20, 32'h8001C300);
    bad_store("op101", 3'b101, 32'h10, 32'h20, 32'h8001C300);
    load("keep10", W, 32'h10, 32'h5AADBEEF);
    load("keep0", W, 32'h0, 32'h0);
    load("keep0_b3", BU, 32'h3, 32'h0);

    // Same-cycle read and store: old value now, new value next cycle
    store("sw30", W, 32'h30, 32'h11111111, 32'h110, 32'h11111111);
    drive(1'b1, W, 32'h30, 32'h22222222, 32'h114);
    push("raw_old", 32'h11111111);
    #1;
    pop_check(ReadData_M);
    tick();
    drive(1'b0, W, 32'h0, 32'h0, 32'h0);
    check_trace("raw_tr", 32'h114, 32'h30, 32'h22222222);
    load("raw_new", W, 32'h30, 32'h22222222);

    // Back-to-back stores each produce their own trace
    drive(1'b1, W, 32'h40, 32'hA5A5A5A5, 32'h200);
    tick();
    check_trace("b2b_a", 32'h200, 32'h40, 32'hA5A5A5A5);
    drive(1'b1, BU, 32'h46, 32'h0000007E, 32'h204);
    tick();
    drive(1'b0, W, 32'h0, 32'h0, 32'h0);
    check_trace("b2b_b", 32'h204, 32'h44, 32'h007E0000);
    load("b2b_la", W, 32'h40, 32'hA5A5A5A5);

    // Fill, then reset coinciding with a store
    store("f0", W, 32'h0, 32'h01234567, 32'h300, 32'h01234567);
    store("f3ffc", W, 32'h3FFC, 32'h89ABCDEF, 32'h304, 32'h89ABCDEF);
    store("f100", W, 32'h100, 32'h13579BDF, 32'h308, 32'h13579BDF);
    load("pre_rst", W, 32'h3FFC, 32'h89ABCDEF);
    reset = 1'b1;
    drive(1'b1, W, 32'h104, 32'hFFFFFFFF, 32'h30C);
    tick();
    reset = 1'b0;
    drive(1'b0, W, 32'h0, 32'h0, 32'h0);
    push("rs_valid", 32'h0); pop_check({31'h0, StoreValid});
    push("rs_pc", 32'h0);    pop_check(StorePC);
    push("rs_addr", 32'h0);  pop_check(StoreAddr);
    push("rs_data", 32'h0);  pop_check(StoreData);
    load("rs_0", W, 32'h0, 32'h0);
    load("rs_3ffc", W, 32'h3FFC, 32'h0);
    load("rs_100", W, 32'h100, 32'h0);
    load("rs_104", W, 32'h104, 32'h0);
    load("rs_10", W, 32'h10, 32'h0);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
